memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Memory (M) stage of the 5-stage MIPS pipeline, directly downstream of execute.
//  Captures execute results, runs LW/LB/LBU/SW/SB on the data memory via req/ack, big-endian byte lanes.
//  Produces the registered M/W result that feeds writeback and serves as the MX forwarding source.
//  Non-memory instructions pass through with one cycle of latency.
// PARAMETERS
//  ADDR_W  32  data-memory byte-address width
// PORTS
//  clock          in   1       single clock, all state on rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  in_valid       in   1       execute presents an instruction
//  in_ready       out  1       stage accepts this cycle (in_valid & in_ready = accept)
//  in_pc          in   32      pc of instruction
//  in_alu_out     in   32      ALU result / effective address
//  in_rb          in   32      store data (execute's forwarded rB)
//  in_dmwe        in   1       store
//  in_rwd         in   1       load (result comes from memory)
//  in_dm_byte     in   1       byte access (LB/LBU/SB); 0 = word
//  in_unsigned    in   1       LBU zero-extend; ignored unless byte load
//  in_rwe         in   1       writes register file
//  in_rd          in   5       destination register
//  dm_req         out  1       memory request, held until dm_ack
//  dm_we          out  1       request is a write
//  dm_addr        out  ADDR_W  word address, bits[1:0] always 00
//  dm_be          out  4       byte enables, bit3 = bits[31:24]
//  dm_wdata       out  32      write data
//  dm_ack         in   1       memory completes the request (read data valid same cycle)
//  dm_rdata       in   32      read word
//  wb_valid       out  1       one-cycle result strobe to writeback
//  wb_rwe         out  1       register write enable
//  wb_rd          out  5       destination register
//  wb_data        out  32      result value; also MX forwarding value
//  wb_pc          out  32      pc of completed instruction
//  misalign       out  1       one-cycle pulse, misaligned word access dropped
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, in_ready 0 only while reset_n low. Async assert mid-request
//   drops dm_req immediately; the transaction is abandoned, no wb_valid.
//  FSM IDLE/WAIT. in_ready = (state==IDLE). wb_valid, misalign are single-cycle pulses.
//  IDLE, accept, non-memory (in_dmwe=0, in_rwd=0): next cycle wb_valid=1, wb_data=in_alu_out,
//   wb_rwe=in_rwe, stay IDLE. Back-to-back accepts give one result per cycle.
//  IDLE, accept, memory op: next cycle dm_req=1 with dm_* registered, state WAIT.
//   dm_addr={in_alu_out[ADDR_W-1:2],2'b00}. Word: dm_be=1111, dm_wdata=in_rb.
//   Byte: dm_be=4'b1000>>addr[1:0], dm_wdata={4{in_rb[7:0]}}.
//  WAIT: dm_req and all dm_* stable until dm_ack sampled high. On that edge dm_req->0, state->IDLE,
//   next cycle wb_valid=1. in_ready stays 0 in the ack cycle: minimum 2 cycles per memory op.
//  Load data: word -> dm_rdata. Byte -> lane dm_rdata[31-8*a -: 8], a=addr[1:0]; sign-extended
//   (LB) or zero-extended (in_unsigned=1, LBU). Store: wb_valid=1, wb_rwe=0, wb_data=in_alu_out.
//  Misaligned word access (in_dm_byte=0, addr[1:0]!=0): no dm_req; next cycle misalign=1,
//   wb_valid=1, wb_rwe=0; stay IDLE.
//  wb_rwe forced 0 when wb_rd==0. wb_rd/wb_data/wb_pc hold their value until the next wb_valid.
//  dm_ack while dm_req=0 is ignored. in_valid=0 in IDLE: wb_valid=0, no state change.
//  Store data is not forwarded to later loads; memory ordering is guaranteed by single outstanding req.
// TESTING
//  Reset mid-WAIT (dm_ack never) -> dm_req, wb_valid, misalign all 0 asynchronously; IDLE after release.
//  ADD result 0x0000_1234 rd=5, 3 back-to-back non-mem -> wb_valid 3 consecutive cycles, 1-cycle latency.
//  LW addr 0x100, dm_ack 3 cycles after dm_req, rdata 0xDEADBEEF -> dm_addr 0x100, be 1111,
//   in_ready low throughout, wb_data 0xDEADBEEF one cycle after ack.
//  LB addr 0x101, rdata 0x11_F0_22_33 -> be 0100, wb_data 0xFFFF_FFF0; same as LBU -> 0x0000_00F0.
//  SB addr 0x203, rb 0x0000_00AB -> dm_we=1, addr 0x200, be 0001, wdata 0xABABABAB, wb_rwe 0.
//  LW addr 0x102 -> no dm_req, misalign pulse, wb_valid with wb_rwe 0; ADD rd=0 -> wb_rwe 0.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage MIPS pipeline.
// Accepts execute results and issues loads and stores to data memory over a
// req/ack port with big-endian byte lanes. Produces the registered M/W result,
// which also serves as the MX forwarding source.
//
// Handshakes:
//   Upstream: an instruction is accepted on a rising edge where in_valid and
//   in_ready are both high. in_ready is high only while the FSM is IDLE and
//   reset_n is released.
//   Memory: dm_req and all dm_* outputs are held stable until a rising edge
//   samples dm_ack high. That edge completes the request, and read data is
//   taken from dm_rdata in the same cycle. dm_ack is ignored while dm_req is
//   low.
module memory_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_alu_out,
  input  logic [31:0]       in_rb,
  input  logic              in_dmwe,
  input  logic              in_rwd,
  input  logic              in_dm_byte,
  input  logic              in_unsigned,
  input  logic              in_rwe,
  input  logic [4:0]        in_rd,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_rwe,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic [31:0]       wb_pc,
  output logic              misalign,
  output logic              state_dbg    // 1 while a memory request is outstanding
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Instruction attributes captured at accept, used when the memory op completes
  logic        pend_load;
  logic        pend_byte;
  logic        pend_unsigned;
  logic        pend_rwe;
  logic [4:0]  pend_rd;
  logic [31:0] pend_pc;
  logic [31:0] pend_alu;

  logic        accept;
  logic        is_mem;
  logic        is_misaligned;
  logic        rd_writes;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;

  assign in_ready      = reset_n && (state == IDLE);
  assign accept        = in_valid && in_ready;
  assign is_mem        = in_dmwe || in_rwd;
  assign is_misaligned = is_mem && !in_dm_byte && (in_alu_out[1:0] != 2'b00);
  // Register 0 is hardwired, so a write to it is suppressed here
  assign rd_writes     = in_rwe && (in_rd != 5'd0);
  assign state_dbg     = (state == WAIT);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: only aligned memory ops enter WAIT, and only dm_ack leaves it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mem && !is_misaligned) state_nxt = WAIT;
      WAIT: if (dm_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Big-endian lane select and extension of the returned read word
  always_comb begin
    lane_byte = 8'h00;
    case (pend_alu[1:0])
      2'd0: lane_byte = dm_rdata[31:24];
      2'd1: lane_byte = dm_rdata[23:16];
      2'd2: lane_byte = dm_rdata[15:8];
      2'd3: lane_byte = dm_rdata[7:0];
      default: lane_byte = 8'h00;
    endcase
    if (pend_byte)
      load_data = {{24{lane_byte[7] & ~pend_unsigned}}, lane_byte};
    else
      load_data = dm_rdata;
  end

  // Memory request, pending-op capture and registered writeback result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_be         <= 4'b0000;
      dm_wdata      <= 32'd0;
      wb_valid      <= 1'b0;
      wb_rwe        <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'd0;
      wb_pc         <= 32'd0;
      misalign      <= 1'b0;
      pend_load     <= 1'b0;
      pend_byte     <= 1'b0;
      pend_unsigned <= 1'b0;
      pend_rwe      <= 1'b0;
      pend_rd       <= 5'd0;
      pend_pc       <= 32'd0;
      pend_alu      <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              // ALU result passes straight through with one cycle of latency
              wb_valid <= 1'b1;
              wb_rwe   <= rd_writes;
              wb_rd    <= in_rd;
              wb_data  <= in_alu_out;
              wb_pc    <= in_pc;
            end else if (is_misaligned) begin
              // Misaligned word access: dropped, reported, never writes back
              wb_valid <= 1'b1;
              misalign <= 1'b1;
              wb_rwe   <= 1'b0;
              wb_rd    <= in_rd;
              wb_data  <= in_alu_out;
              wb_pc    <= in_pc;
            end else begin
              dm_req        <= 1'b1;
              dm_we         <= in_dmwe;
              dm_addr       <= {in_alu_out[ADDR_W-1:2], 2'b00};
              dm_be         <= in_dm_byte ? (4'b1000 >> in_alu_out[1:0]) : 4'b1111;
              dm_wdata      <= in_dm_byte ? {4{in_rb[7:0]}} : in_rb;
              pend_load     <= in_rwd && !in_dmwe;
              pend_byte     <= in_dm_byte;
              pend_unsigned <= in_unsigned;
              pend_rwe      <= rd_writes;
              pend_rd       <= in_rd;
              pend_pc       <= in_pc;
              pend_alu      <= in_alu_out;
            end
          end
        end
        WAIT: begin
          if (dm_ack) begin
            dm_req   <= 1'b0;
            wb_valid <= 1'b1;
            wb_rwe   <= pend_load && pend_rwe;
            wb_rd    <= pend_rd;
            wb_data  <= pend_load ? load_data : pend_alu;
            wb_pc    <= pend_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by randomized ops,
// checked against a word-addressed memory model and a writeback scoreboard.
module tb_memory_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_out;
  logic [31:0] in_rb;
  logic        in_dmwe;
  logic        in_rwd;
  logic        in_dm_byte;
  logic        in_unsigned;
  logic        in_rwe;
  logic [4:0]  in_rd;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_valid;
  logic        wb_rwe;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        misalign;
  logic        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of expected wb_data values and the model of data memory
  logic [31:0] exp_q[$];
  logic [31:0] mem_words[int unsigned];
  logic [31:0] last_wb_data;

  memory_stage #(.ADDR_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_alu_out(in_alu_out), .in_rb(in_rb), .in_dmwe(in_dmwe),
    .in_rwd(in_rwd), .in_dm_byte(in_dm_byte), .in_unsigned(in_unsigned),
    .in_rwe(in_rwe), .in_rd(in_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_rwe(wb_rwe), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .misalign(misalign), .state_dbg(state_dbg)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] waddr);
    if (!mem_words.exists(waddr)) mem_words[waddr] = $urandom;
    return mem_words[waddr];
  endfunction

  task automatic set_op(input logic [31:0] pc, alu, rb, input logic dmwe, rwd, bsel, uns, rwe,
                        input logic [4:0] rd);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_alu_out  = alu;
    in_rb       = rb;
    in_dmwe     = dmwe;
    in_rwd      = rwd;
    in_dm_byte  = bsel;
    in_unsigned = uns;
    in_rwe      = rwe;
    in_rd       = rd;
  endtask

  // Drives one instruction from a negedge and checks it through to its writeback;
  // ends on the negedge where the result is visible.
  task automatic run_op(input logic [31:0] pc, alu, rb, input logic dmwe, rwd, bsel, uns, rwe,
                        input logic [4:0] rd, input int lat);
    logic        mem_op, misal, load;
    logic [31:0] waddr, word, b, result;
    logic [3:0]  be;
    int          a;
    mem_op = dmwe || rwd;
    misal  = mem_op && !bsel && (alu % 4 != 0);
    load   = rwd && !dmwe;
    a      = alu % 4;
    waddr  = alu - (alu % 4);
    be     = bsel ? 4'(8 >> a) : 4'b1111;
    set_op(pc, alu, rb, dmwe, rwd, bsel, uns, rwe, rd);
    check("in_ready_before_accept", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    result = alu;
    if (mem_op && !misal) begin
      check("dm_req_issued", dm_req, 1);
      check("dm_we", dm_we, dmwe);
      check("dm_addr", dm_addr, waddr);
      check("dm_be", dm_be, be);
      if (dmwe) check("dm_wdata", dm_wdata, bsel ? rb[7:0] * 32'h0101_0101 : rb);
      check("wb_valid_during_req", wb_valid, 0);
      for (int i = 0; i < lat; i++) begin
        check("in_ready_wait", in_ready, 0);
        @(negedge clock);
        check("dm_req_held", dm_req, 1);
        check("dm_addr_held", dm_addr, waddr);
      end
      check("in_ready_ack_cycle", in_ready, 0);
      word = mem_read(waddr);
      if (load) begin
        if (bsel) begin
          b = (word >> (8 * (3 - a))) % 256;
          result = (!uns && b >= 128) ? b + 32'hFFFF_FF00 : b;
        end else begin
          result = word;
        end
      end else begin
        // Store: merge the written lanes into the memory model
        if (bsel)
          mem_words[waddr] = (word & ~(32'hFF << (8 * (3 - a)))) | ({24'd0, rb[7:0]} << (8 * (3 - a)));
        else
          mem_words[waddr] = rb;
      end
      dm_ack   = 1'b1;
      dm_rdata = load ? word : $urandom;
      @(negedge clock);
      dm_ack   = 1'b0;
      dm_rdata = $urandom;
      check("dm_req_dropped", dm_req, 0);
    end else begin
      check("dm_req_idle", dm_req, 0);
    end
    check("wb_valid", wb_valid, 1);
    check("misalign", misalign, misal);
    check("wb_rwe", wb_rwe, (misal || dmwe) ? 1'b0 : (rwe && rd != 0));
    check("wb_rd", wb_rd, rd);
    check("wb_pc", wb_pc, pc);
    check("state_idle_after", state_dbg, 0);
    if (!misal) begin
      exp_q.push_back(result);
      check("wb_data", wb_data, exp_q.pop_front());
    end
    last_wb_data = wb_valid ? (misal ? wb_data : result) : last_wb_data;
  endtask

  // Stimulus and report
  initial begin
    logic [31:0] alu;
    int          kind;
    reset_n = 1'b0; in_valid = 1'b0; in_pc = 0; in_alu_out = 0; in_rb = 0;
    in_dmwe = 0; in_rwd = 0; in_dm_byte = 0; in_unsigned = 0; in_rwe = 0; in_rd = 0;
    dm_ack = 1'b0; dm_rdata = 32'd0;
    last_wb_data = 32'd0;
    repeat (2) @(negedge clock);
    check("reset_in_ready", in_ready, 0);
    check("reset_dm_req", dm_req, 0);
    check("reset_wb_valid", wb_valid, 0);
    check("reset_wb_data", wb_data, 0);
    check("reset_misalign", misalign, 0);
    check("reset_state", state_dbg, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_in_ready", in_ready, 1);

    // Three back-to-back ALU results, one per cycle
    set_op(32'h10, 32'h0000_1234, 0, 0, 0, 0, 0, 1, 5'd5);
    @(negedge clock);
    check("b2b0_wb_valid", wb_valid, 1);
    check("b2b0_wb_data", wb_data, 32'h0000_1234);
    check("b2b0_wb_rwe", wb_rwe, 1);
    check("b2b0_in_ready", in_ready, 1);
    set_op(32'h14, 32'h0000_1235, 0, 0, 0, 0, 0, 1, 5'd6);
    @(negedge clock);
    check("b2b1_wb_valid", wb_valid, 1);
    check("b2b1_wb_data", wb_data, 32'h0000_1235);
    set_op(32'h18, 32'h0000_1236, 0, 0, 0, 0, 0, 1, 5'd7);
    @(negedge clock);
    check("b2b2_wb_valid", wb_valid, 1);
    check("b2b2_wb_data", wb_data, 32'h0000_1236);
    check("b2b2_wb_pc", wb_pc, 32'h18);
    in_valid = 1'b0;
    @(negedge clock);
    check("idle_wb_valid", wb_valid, 0);
    check("hold_wb_data", wb_data, 32'h0000_1236);
    check("hold_wb_rd", wb_rd, 7);

    // LW with 3-cycle ack latency, LB/LBU lane extraction, SB lane replication
    mem_words[32'h100] = 32'hDEAD_BEEF;
    run_op(32'h20, 32'h100, 0, 0, 1, 0, 0, 1, 5'd8, 3);
    mem_words[32'h100] = 32'h11F0_2233;
    run_op(32'h24, 32'h101, 0, 0, 1, 1, 0, 1, 5'd9, 1);
    run_op(32'h28, 32'h101, 0, 0, 1, 1, 1, 1, 5'd10, 0);
    run_op(32'h2C, 32'h203, 32'h0000_00AB, 1, 0, 1, 0, 0, 5'd0, 2);
    run_op(32'h30, 32'h200, 0, 0, 1, 0, 0, 1, 5'd11, 0);
    // Misaligned LW, then an ALU op targeting r0
    run_op(32'h34, 32'h102, 0, 0, 1, 0, 0, 1, 5'd12, 0);
    run_op(32'h38, 32'h55, 0, 0, 0, 0, 0, 1, 5'd0, 0);

    // dm_ack with no request outstanding
    dm_ack = 1'b1;
    @(negedge clock);
    dm_ack = 1'b0;
    check("stray_ack_wb_valid", wb_valid, 0);
    check("stray_ack_dm_req", dm_req, 0);
    check("stray_ack_state", state_dbg, 0);

    // Randomized mix of ALU, word/byte loads and stores, and misaligned accesses
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 6);
      alu  = 32'h300 + ($urandom_range(0, 15) * 4);
      case (kind)
        0: run_op(32'h4000 + i * 4, $urandom, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 0);
        1: run_op(32'h4000 + i * 4, alu, 0, 0, 1, 0, 0, 1, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        2: run_op(32'h4000 + i * 4, alu + $urandom_range(0, 3), 0, 0, 1, 1, 1'($urandom_range(0, 1)), 1,
                  5'($urandom_range(0, 31)), $urandom_range(0, 3));
        3: run_op(32'h4000 + i * 4, alu, $urandom, 1, 0, 0, 0, 0, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        4: run_op(32'h4000 + i * 4, alu + $urandom_range(0, 3), $urandom, 1, 0, 1, 0, 0,
                  5'($urandom_range(0, 31)), $urandom_range(0, 3));
        5: run_op(32'h4000 + i * 4, alu + $urandom_range(1, 3), 0, 0, 1, 0, 0, 1, 5'($urandom_range(0, 31)), 0);
        default: run_op(32'h4000 + i * 4, alu + $urandom_range(1, 3), $urandom, 1, 0, 0, 0, 0, 5'($urandom_range(0, 31)), 0);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        check("rand_gap_wb_valid", wb_valid, 0);
        check("rand_gap_hold_wb_data", wb_data, last_wb_data);
      end
    end

    // Asynchronous reset while a request waits for an ack that never comes
    set_op(32'h80, 32'h180, 0, 0, 1, 0, 0, 1, 5'd3);
    @(negedge clock);
    in_valid = 1'b0;
    check("pre_reset_dm_req", dm_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_dm_req", dm_req, 0);
    check("async_reset_wb_valid", wb_valid, 0);
    check("async_reset_misalign", misalign, 0);
    check("async_reset_in_ready", in_ready, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_state", state_dbg, 0);
    check("post_reset_wb_valid", wb_valid, 0);
    check("post_reset_dm_req", dm_req, 0);
    run_op(32'h84, 32'h0000_0777, 0, 0, 0, 0, 0, 1, 5'd4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
